// File: rtl/hex_scan_driver.sv
// hex_scan_driver: scans four hex digits onto a multiplexed display, with
// blanking gaps, leading-zero suppression and a shadow register for updates.
module hex_scan_driver #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] value_in,
   input  logic        value_valid,
   output logic        value_ready,
   input  logic        lz_suppress,
   output logic [3:0]  digit,
   output logic        digit_blank,
   output logic [3:0]  anode
);
   localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t        state_q, state_d;
   logic [15:0]   shadow_q, shadow_d, disp_q, disp_d, upper;
   logic          pending_q, pending_d, step, xfer;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    anode_q, anode_d, digit_q, digit_d;
   logic          blank_q, blank_d;

   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      cnt_d = cnt_q + CW'(1);
      step = 1'b0;
      case (state_q)
         SHOW: if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) step = 1'b1;
            else state_d = BLANK;
         end
         BLANK: if (cnt_q == BLANK_LAST) begin
            cnt_d = '0;
            step = 1'b1;
            state_d = SHOW;
         end
         default: begin
            cnt_d = '0;
            idx_d = 2'd0;
            state_d = enable ? SHOW : IDLE;
         end
      endcase
      if (step) idx_d = idx_q + 2'd1;
      if (state_q != IDLE && !enable) begin
         state_d = IDLE;
         idx_d = 2'd0;
         cnt_d = '0;
         step = 1'b0;
      end
      // new digits only land at a scan-frame boundary so a frame never mixes values
      xfer = pending_q && (state_q == IDLE || (step && idx_q == 2'd3));
      disp_d = xfer ? shadow_q : disp_q;
      pending_d = xfer ? 1'b0 : pending_q;
      shadow_d = shadow_q;
      if (value_valid && !pending_q) begin
         shadow_d = value_in;
         pending_d = 1'b1;
      end
      upper = disp_d >> {idx_d, 2'b00};
      anode_d = (state_d == SHOW) ? ~(4'b0001 << idx_d) : 4'b1111;
      digit_d = (state_d == SHOW) ? upper[3:0] : 4'h0;
      blank_d = (state_d != SHOW) || (lz_suppress && idx_d != 2'd0 && upper == 16'h0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q <= 2'd0;
         cnt_q <= '0;
         disp_q <= 16'h0;
         shadow_q <= 16'h0;
         pending_q <= 1'b0;
         anode_q <= 4'b1111;
         digit_q <= 4'h0;
         blank_q <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         disp_q <= disp_d;
         shadow_q <= shadow_d;
         pending_q <= pending_d;
         anode_q <= anode_d;
         digit_q <= digit_d;
         blank_q <= blank_d;
      end
   end

   assign value_ready = !pending_q;
   assign anode = anode_q;
   assign digit = digit_q;
   assign digit_blank = blank_q;
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: three parameterisations against a time-based scan model.
module tb_hex_scan_driver;
   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset, enable, value_valid, lz_suppress;
   logic [15:0] value_in;
   logic [3:0]  anode [N];
   logic [3:0]  digit [N];
   logic        digit_blank [N];
   logic        value_ready [N];

   bit          run [N];
   int          t [N];
   logic [15:0] m_shadow [N];
   logic [15:0] m_disp [N];
   bit          m_pend [N];
   bit          m_lz [N];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   hex_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .value_in(value_in),
      .value_valid(value_valid), .value_ready(value_ready[0]), .lz_suppress(lz_suppress),
      .digit(digit[0]), .digit_blank(digit_blank[0]), .anode(anode[0]));
   hex_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .value_in(value_in),
      .value_valid(value_valid), .value_ready(value_ready[1]), .lz_suppress(lz_suppress),
      .digit(digit[1]), .digit_blank(digit_blank[1]), .anode(anode[1]));
   hex_scan_driver #(.REFRESH_DIV(1), .BLANK_CYCLES(1)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .value_in(value_in),
      .value_valid(value_valid), .value_ready(value_ready[2]), .lz_suppress(lz_suppress),
      .digit(digit[2]), .digit_blank(digit_blank[2]), .anode(anode[2]));

   function automatic int rd(input int k);
      return (k == 2) ? 1 : 4;
   endfunction

   function automatic int bc(input int k);
      return (k == 0) ? 2 : (k == 1) ? 0 : 1;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scan position is derived from elapsed cycles since the scan started.
   task automatic model_step(input int k);
      bit hs;
      int p;
      p = 4 * (rd(k) + bc(k));
      hs = value_valid && !m_pend[k];
      m_lz[k] = lz_suppress;
      if (reset) begin
         run[k] = 0;
         t[k] = 0;
         m_shadow[k] = 16'h0;
         m_disp[k] = 16'h0;
         m_pend[k] = 0;
         return;
      end
      if (!run[k]) begin
         if (m_pend[k]) begin
            m_disp[k] = m_shadow[k];
            m_pend[k] = 0;
         end
         if (enable) begin
            run[k] = 1;
            t[k] = 0;
         end
      end else if (!enable) begin
         run[k] = 0;
      end else begin
         t[k]++;
         if (t[k] % p == 0 && m_pend[k]) begin
            m_disp[k] = m_shadow[k];
            m_pend[k] = 0;
         end
      end
      if (hs) begin
         m_shadow[k] = value_in;
         m_pend[k] = 1;
      end
   endtask

   task automatic check_outputs(input int k);
      logic [3:0]  ea, ed;
      logic        eb;
      logic [15:0] nib;
      int          s, i;
      ea = 4'b1111;
      ed = 4'h0;
      eb = 1'b1;
      if (run[k]) begin
         s = t[k] % (rd(k) + bc(k));
         i = (t[k] / (rd(k) + bc(k))) % 4;
         if (s < rd(k)) begin
            nib = m_disp[k] >> (4 * i);
            ea = ~(4'b0001 << i);
            ed = nib[3:0];
            eb = m_lz[k] && i > 0 && nib == 16'h0;
         end
      end
      check($sformatf("anode%0d", k), {12'h0, anode[k]}, {12'h0, ea});
      check($sformatf("digit%0d", k), {12'h0, digit[k]}, {12'h0, ed});
      check($sformatf("blank%0d", k), {15'h0, digit_blank[k]}, {15'h0, eb});
      check($sformatf("ready%0d", k), {15'h0, value_ready[k]}, {15'h0, !m_pend[k]});
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int k = 0; k < N; k++) model_step(k);
      @(negedge clk);
      for (int k = 0; k < N; k++) check_outputs(k);
   endtask

   function automatic logic [15:0] pick();
      logic [15:0] tbl [5];
      tbl = '{16'h1234, 16'hABCD, 16'h0050, 16'h0000, 16'h000F};
      return ($urandom_range(0, 5) == 5) ? 16'($urandom) : tbl[$urandom_range(0, 4)];
   endfunction

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      value_valid = 1'b1;
      value_in = 16'hFFFF;
      lz_suppress = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      enable = 1'b0;
      value_in = 16'h1234;
      cycle();
      value_valid = 1'b0;
      enable = 1'b1;
      for (int c = 0; c < 60; c++) cycle();
      value_valid = 1'b1;
      value_in = 16'h0050;
      lz_suppress = 1'b1;
      cycle();
      value_valid = 1'b0;
      for (int c = 0; c < 60; c++) cycle();
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if (enable ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0)) enable = !enable;
         if ($urandom_range(0, 49) == 0) lz_suppress = !lz_suppress;
         value_valid = ($urandom_range(0, 5) == 0);
         value_in = pick();
         cycle();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles each digit is lit per scan slot (legal >= 1).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000, meaning all-anodes-off clk cycles between slots (legal >= 0).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 The block SHALL have port enable, input, 1, scanning runs while high.
REQ-006 The block SHALL have port value_in, input, 16, four hex digits; [3:0] is digit 0 (rightmost).
REQ-007 The block SHALL have port value_valid, input, 1, value_in offered this cycle.
REQ-008 The block SHALL have port value_ready, output, 1, the block can accept value_in.
REQ-009 The block SHALL have port lz_suppress, input, 1, enables leading-zero blanking.
REQ-010 The block SHALL have port digit, output, 4, nibble for the downstream 7-segment decoder.
REQ-011 The block SHALL have port digit_blank, output, 1, high means the downstream segments are forced off.
REQ-012 The block SHALL have port anode, output, 4, active-low digit select; bit i selects digit i.

Function
REQ-013 The block SHALL hold registers: shadow[15:0], pending, disp[15:0], idx[1:0], a slot counter and state {IDLE, SHOW, BLANK}.
REQ-014 value_ready SHALL equal !pending; on value_valid && value_ready, shadow SHALL load value_in and pending SHALL set on the same edge.
REQ-015 A pending shadow SHALL transfer to disp (pending cleared) only on the BLANK->SHOW edge where idx wraps 3->0, or on any edge while in IDLE.
REQ-016 IDLE SHALL go to SHOW with idx=0 and counter=0 on the edge after enable is seen high.
REQ-017 SHOW SHALL last exactly REFRESH_DIV cycles, then go to BLANK, or directly to SHOW at the next idx if BLANK_CYCLES=0.
REQ-018 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to SHOW with idx incremented modulo 4.
REQ-019 When enable is low in SHOW or BLANK, the next state SHALL be IDLE with idx=0 and counter=0.
REQ-020 In SHOW, anode SHALL be all ones except anode[idx]=0, and digit SHALL be disp[4*idx+3:4*idx].
REQ-021 In IDLE and BLANK, anode SHALL be 4'b1111, digit_blank=1 and digit=4'h0.
REQ-022 In SHOW, digit_blank SHALL be 1 iff lz_suppress=1, idx>0, and disp bits [15:4*idx] are all zero; digit 0 SHALL never be suppressed.
REQ-023 anode, digit and digit_blank SHALL depend only on registered state, with no combinational path from any input.
REQ-024 The full scan period SHALL be 4*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-025 Counter width SHALL be sized from the larger parameter; the counter SHALL never wrap inside a slot.

Reset
REQ-026 On reset, state SHALL be IDLE and idx, counter, disp, shadow and pending SHALL be 0.
REQ-027 During and after reset, outputs SHALL be anode=4'b1111, digit=0, digit_blank=1 and value_ready=1.
REQ-028 Reset SHALL override enable and any value_valid on the same edge; a handshake in the reset cycle SHALL be discarded.
REQ-029 Reset mid-scan SHALL turn all anodes off on the next cycle.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2 unless stated)
REQ-030 Reset, load 16'h1234 while IDLE, then enable=1 -> anode 1110/digit 4 for 4 cycles, 1111 for 2 cycles, then 1101/3, 1011/2, 0111/1; period 24 cycles.
REQ-031 Load 16'hABCD during the idx=1 slot -> value_ready drops for 1+ cycles; digits 2 and 3 still show the old value; A..D appear from the next idx=0 slot; value_ready returns 1 the cycle after transfer.
REQ-032 disp=16'h0050, lz_suppress=1 -> digit_blank = 0,0,1,1 for idx 0..3; with lz_suppress=0 all are 0; disp=0 -> only digit 0 unblanked, showing 0.
REQ-033 Drop enable mid-SHOW at idx=2 -> next cycle anode=1111 (IDLE); re-enable -> scan restarts at idx=0 with a full 4-cycle slot.
REQ-034 Assert reset during BLANK with value_valid=1 -> state IDLE, pending=0, disp=0, value_ready=1; the offered value is not stored.
REQ-035 With BLANK_CYCLES=0 -> anode never reaches 1111 while enabled; slots are back-to-back at 4 cycles each; period 16.
